// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_MOV   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_DIFF  = 4'b0100;
    localparam logic [3:0] OP_COMP  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b0111;
    // Any opcode with bit 3 set is a shift; bits [2:0] pick source/direction/kind.
    localparam logic [3:0] OP_SHIFT = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the datapath controller and alu_mc.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             f_zero;
    logic             f_sign;
    logic             f_carry;
    logic             f_ovf;

    modport master (
        output in_valid, a, b, alu_op, shamt, out_ready,
        input  in_ready, out_valid, result, f_zero, f_sign, f_carry, f_ovf
    );

    modport slave (
        input  in_valid, a, b, alu_op, shamt, out_ready,
        output in_ready, out_valid, result, f_zero, f_sign, f_carry, f_ovf
    );

endinterface

// File: rtl/alu_shifter_p.sv
// Barrel shifter: left/right, logical/arithmetic, amount wraps to SHW bits.
module alu_shifter_p #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   amt,
    input  logic             left,
    input  logic             logical,
    output logic [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] din_s;

    assign din_s = din;

    // Left arithmetic and left logical are the same operation.
    always_comb begin
        dout = '0;
        if (left) begin
            dout = din << amt;
        end else if (logical) begin
            dout = din >> amt;
        end else begin
            dout = $unsigned(din_s >>> amt);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete on the accept edge, MUL iterates
// one shift-add per cycle; result and flags are registered behind a valid/ready pair.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mc_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Lowest differing bit index; WIDTH when the operands are equal.
    function automatic logic [WIDTH-1:0] diff_index(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] idx;
        idx = WIDTH'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                idx = WIDTH'(i);
            end
        end
        return idx;
    endfunction

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic                    in_ready;
    logic                    accept;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH:0]          sum_add;
    logic [WIDTH:0]          sum_sub;
    logic [WIDTH:0]          sum_cmp;
    logic [SHW-1:0]          sh_amt;
    logic [WIDTH-1:0]        sh_res;
    logic [WIDTH-1:0]        op_res;
    logic                    op_upd_c;
    logic                    op_c;
    logic                    op_upd_v;
    logic                    op_v;

    assign a_s     = bus.a;
    assign b_s     = bus.b;
    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    assign sum_cmp = {1'b0, ~bus.b} + (WIDTH+1)'(1);
    assign sh_amt  = bus.alu_op[2] ? bus.b[SHW-1:0] : bus.shamt;

    alu_shifter_p #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .din     (bus.a),
        .amt     (sh_amt),
        .left    (bus.alu_op[1]),
        .logical (bus.alu_op[0]),
        .dout    (sh_res)
    );

    assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Single-cycle result and which of carry/ovf the op is allowed to touch.
    always_comb begin
        op_res   = '0;
        op_upd_c = 1'b0;
        op_c     = 1'b0;
        op_upd_v = 1'b0;
        op_v     = 1'b0;
        if (is_shift(bus.alu_op)) begin
            op_res = sh_res;
        end else begin
            case (bus.alu_op)
                OP_MOV: op_res = bus.a;
                OP_ADD: begin
                    op_res   = sum_add[WIDTH-1:0];
                    op_upd_c = 1'b1;
                    op_c     = sum_add[WIDTH];
                    op_upd_v = 1'b1;
                    op_v     = add_ovf(a_s, b_s, sum_add[WIDTH-1:0]);
                end
                OP_AND:  op_res = bus.a & bus.b;
                OP_XOR:  op_res = bus.a ^ bus.b;
                OP_DIFF: op_res = diff_index(bus.a ^ bus.b);
                OP_COMP: begin
                    op_res   = sum_cmp[WIDTH-1:0];
                    op_upd_c = 1'b1;
                    op_c     = sum_cmp[WIDTH];
                end
                OP_SUB: begin
                    op_res   = sum_sub[WIDTH-1:0];
                    op_upd_c = 1'b1;
                    op_c     = sum_sub[WIDTH];
                    op_upd_v = 1'b1;
                    op_v     = sub_ovf(a_s, b_s, sum_sub[WIDTH-1:0]);
                end
                default: op_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.alu_op == OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        sign_d      = op_res[WIDTH-1];
                        carry_d     = op_upd_c ? op_c : carry_q;
                        ovf_d       = op_upd_v ? op_v : ovf_q;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // One partial product per cycle; the cycle after the count hits zero publishes.
                if (cnt_q != '0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    result_d    = acc_q;
                    zero_d      = (acc_q == '0);
                    sign_d      = acc_q[WIDTH-1];
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Multiplier working registers are only meaningful in ST_MUL.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.f_zero    = zero_q;
    assign bus.f_sign    = sign_q;
    assign bus.f_carry   = carry_q;
    assign bus.f_ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32.
module tb_alu_mc;

    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_bad;
    int   cyc;
    bit   rnd_rdy;
    bit   m_c;
    bit   m_v;
    logic [35:0] sb_q[$];
    logic [35:0] mon_exp;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model; returns {zero, sign, carry, ovf, result}.
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic [32:0] t;
        logic [63:0] p;
        logic [4:0]  amt;
        longint      s;
        r = 32'h0;
        case (op)
            4'd0: r = a;
            4'd1: begin
                t   = {1'b0, a} + {1'b0, b};
                r   = t[31:0];
                m_c = t[32];
                s   = longint'($signed(a)) + longint'($signed(b));
                m_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: begin
                r = 32'd32;
                for (int i = 31; i >= 0; i--) if (a[i] != b[i]) r = 32'(i);
            end
            4'd5: begin
                r   = 32'h0 - b;
                m_c = (b == 32'h0);
            end
            4'd6: begin
                r   = a - b;
                m_c = (a >= b);
                s   = longint'($signed(a)) - longint'($signed(b));
                m_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0];
            end
            default: begin
                amt = op[2] ? b[4:0] : sh;
                if (op[1])      r = a << amt;
                else if (op[0]) r = a >> amt;
                else            r = $unsigned($signed(a) >>> amt);
            end
        endcase
        return {(r == 32'h0), r[31], m_c, m_v, r};
    endfunction

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        while (!done && n < 300) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(model(op, a, b, sh));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                n++;
                if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.alu_op   = 4'($urandom_range(0, 15));
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_result", 64'({bus.f_zero, bus.f_sign, bus.f_carry, bus.f_ovf, bus.result}),
                    64'(mon_exp));
            end
        end
    end

    function automatic logic [63:0] dut_state();
        return 64'({bus.f_zero, bus.f_sign, bus.f_carry, bus.f_ovf, bus.result});
    endfunction

    initial begin
        int n;
        int c0;
        bit hi;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tot = 0;
        n_bad = 0;
        cyc = 0;
        rnd_rdy = 1'b0;
        m_c = 1'b0;
        m_v = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.alu_op = 4'h0;
        bus.shamt = 5'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_state", dut_state(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        send(4'b0001, 32'hFFFF_FFFF, 32'h1, 5'd0);
        chk("add_latency", 64'(bus.out_valid), 64'd1);
        chk("add_direct", dut_state(), {28'h0, 4'b1010, 32'h0});

        send(4'b0110, 32'h8000_0000, 32'h1, 5'd0);
        chk("sub_direct", dut_state(), {28'h0, 4'b0011, 32'h7FFF_FFFF});
        send(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        chk("and_holds_cv", dut_state(), {28'h0, 4'b0011, 32'h00F0_00F0});

        send(4'b0111, 32'h0001_0003, 32'h5, 5'd0);
        n  = 0;
        hi = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) hi = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_latency", 64'(n), 64'd33);
        chk("mul_in_ready_low", 64'(hi), 64'd0);
        chk("mul_direct", dut_state(), {28'h0, 4'b0011, 32'h0005_000F});

        send(4'b1000, 32'h8000_0000, 32'h0, 5'd4);
        chk("sra_direct", 64'(bus.result), 64'h0000_0000_F800_0000);
        send(4'b1111, 32'h1, 32'h4, 5'd0);
        chk("sll_b_direct", 64'(bus.result), 64'h10);
        send(4'b1101, 32'h100, 32'h4, 5'd31);
        chk("srl_b_direct", 64'(bus.result), 64'h10);
        send(4'b0101, 32'h0, 32'h0, 5'd0);
        send(4'b0100, 32'h0F0, 32'h0B0, 5'd0);
        chk("diff_direct", 64'(bus.result), 64'd6);

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(4'b0100, 32'h1234_5678, 32'h1234_5678, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_result", 64'(bus.result), 64'd32);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;

        c0 = cyc;
        send(4'b0001, 32'h7FFF_FFFF, 32'h1, 5'd0);
        send(4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
        send(4'b0000, 32'hDEAD_BEEF, 32'h0, 5'd0);
        send(4'b1010, 32'h0000_0003, 32'h0, 5'd30);
        chk("throughput", 64'(cyc - c0), 64'd4);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if (i % 9 == 0) rb = 32'h0;
            bus.out_ready = 1'($urandom_range(0, 1));
            send(op, ra, rb, 5'($urandom_range(0, 31)));
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;

        send(4'b0110, 32'h8000_0000, 32'h1, 5'd0);
        send(4'b0111, 32'h3, 32'h7, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_state", dut_state(), 64'd0);
        sb_q.delete();
        m_c = 1'b0;
        m_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0001, 32'h2, 32'h3, 5'd0);
        chk("post_rst_add", dut_state(), 64'd5);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
